// File: rtl/onehot_codec_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onehot_codec_if                                                       |
// | Operation/result handshake bundle for onehot_codec_pipe.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface onehot_codec_if #(
    parameter int SEL_W = 3
);
    localparam int N = 2 ** SEL_W;

    logic             en_b;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel_in;
    logic [N-1:0]     req_b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     dec_out_b;
    logic [SEL_W-1:0] enc_out;
    logic             enc_hit;

    modport master (
        output en_b, mode, in_valid, sel_in, req_b, out_ready,
        input  in_ready, out_valid, dec_out_b, enc_out, enc_hit
    );

    modport slave (
        input  en_b, mode, in_valid, sel_in, req_b, out_ready,
        output in_ready, out_valid, dec_out_b, enc_out, enc_hit
    );
endinterface
`default_nettype wire

// File: rtl/onehot_codec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | onehot_codec_pipe                                                     |
// | One-hot decoder / priority encoder with a DEPTH-entry result FIFO.    |
// | Define ONEHOT_CODEC_RR_EN for rotating (round-robin) encode priority. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module onehot_codec_pipe #(
    parameter int SEL_W = 3,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    onehot_codec_if.slave  bus
);
    localparam int N  = 2 ** SEL_W;
    localparam int EW = N + SEL_W + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [EW-1:0]    r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [SEL_W-1:0] w_win;
    logic             w_any;
    logic [N-1:0]     w_dec;
    logic [SEL_W-1:0] w_enc;
    logic             w_hit;
    logic [EW-1:0]    w_head;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ONEHOT_CODEC_RR_EN
    logic [SEL_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_push && !bus.en_b && bus.mode && w_any) begin
            r_ptr <= w_win + 1'b1;
        end
    end
`endif

    // Descending scan so the lowest offset from the start point wins last.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
`ifdef ONEHOT_CODEC_RR_EN
            if (!bus.req_b[r_ptr + SEL_W'(i)]) begin
                w_win = r_ptr + SEL_W'(i);
                w_any = 1'b1;
            end
`else
            if (!bus.req_b[i]) begin
                w_win = SEL_W'(i);
                w_any = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        w_dec = '1;
        w_enc = '0;
        w_hit = 1'b0;
        if (bus.en_b) begin
            w_enc = '1;
        end else if (!bus.mode) begin
            w_dec[bus.sel_in] = 1'b0;
        end else begin
            w_enc = w_win;
            w_hit = w_any;
        end
    end

    assign w_nonempty    = (r_count != '0);
    assign bus.in_ready  = (r_count < CW'(DEPTH));
    assign bus.out_valid = w_nonempty;
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = w_nonempty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            if (w_push) r_wr <= f_next(r_wr);
            if (w_pop)  r_rd <= f_next(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr] <= {w_dec, w_enc, w_hit};
        end
    end

    assign w_head        = r_mem[r_rd];
    assign bus.dec_out_b = w_nonempty ? w_head[EW-1 -: N]     : '1;
    assign bus.enc_out   = w_nonempty ? w_head[SEL_W:1]       : '0;
    assign bus.enc_hit   = w_nonempty ? w_head[0]             : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_onehot_codec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_onehot_codec_pipe                                                  |
// | Directed self-checking bench for onehot_codec_pipe (SEL_W=3,DEPTH=2). |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_onehot_codec_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    onehot_codec_if #(.SEL_W(3)) bus ();

    onehot_codec_pipe #(.SEL_W(3), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [7:0] dec, input logic [2:0] enc, input logic hit);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".dec"},   32'(bus.dec_out_b), 32'(dec));
        check({tag, ".enc"},   32'(bus.enc_out),   32'(enc));
        check({tag, ".hit"},   32'(bus.enc_hit),   32'(hit));
    endtask

    task automatic offer(input logic m, input logic eb, input logic [2:0] sel, input logic [7:0] req);
        bus.mode = m; bus.en_b = eb; bus.sel_in = sel; bus.req_b = req;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.en_b = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
        bus.sel_in = '0; bus.req_b = '1; bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.ready", 32'(bus.in_ready),  32'd1);
        check("rst.dec",   32'(bus.dec_out_b), 32'hFF);
        check("rst.enc",   32'(bus.enc_out),   32'd0);
        check("rst.hit",   32'(bus.enc_hit),   32'd0);

        // Decode sel 5 with consumer ready: one-cycle latency, then drains.
        bus.out_ready = 1'b1;
        offer(1'b0, 1'b0, 3'd5, 8'hFF);
        head("dec5", 8'hDF, 3'd0, 1'b0);
        tick();
        check("dec5.drain", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        offer(1'b1, 1'b0, 3'd0, 8'b1110_0111);
        head("enc3", 8'hFF, 3'd3, 1'b1);
        tick();
        head("enc3.hold", 8'hFF, 3'd3, 1'b1);
        pop();

        // Back-to-back decodes with stalled consumer fill the buffer.
        bus.mode = 1'b0; bus.en_b = 1'b0; bus.in_valid = 1'b1;
        bus.sel_in = 3'd0;
        tick();
        check("fill1.ready", 32'(bus.in_ready), 32'd1);
        bus.sel_in = 3'd1;
        tick();
        check("fill2.ready", 32'(bus.in_ready), 32'd0);
        bus.sel_in = 3'd2;
        tick();
        check("full.ready", 32'(bus.in_ready), 32'd0);
        head("full.h0", 8'hFE, 3'd0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        head("drain.h1", 8'hFD, 3'd0, 1'b0);
        check("drain.ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        head("drain.h2", 8'hFB, 3'd0, 1'b0);
        tick();
        check("drain.empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        offer(1'b0, 1'b1, 3'd7, 8'hFF);
        head("dis", 8'hFF, 3'd7, 1'b0);
        pop();
        offer(1'b1, 1'b0, 3'd0, 8'hFF);
        head("noreq", 8'hFF, 3'd0, 1'b0);
        pop();
        offer(1'b1, 1'b0, 3'd0, 8'h7F);
        head("enc7", 8'hFF, 3'd7, 1'b1);
        pop();

        // After the line-7 win the rotating pointer wraps back to 0.
        offer(1'b1, 1'b0, 3'd0, 8'b1110_1110);
        head("pri.a", 8'hFF, 3'd0, 1'b1);
        pop();
        offer(1'b1, 1'b0, 3'd0, 8'b1110_1110);
`ifdef ONEHOT_CODEC_RR_EN
        head("pri.b", 8'hFF, 3'd4, 1'b1);
`else
        head("pri.b", 8'hFF, 3'd0, 1'b1);
`endif
        pop();
        offer(1'b1, 1'b0, 3'd0, 8'b1110_1110);
        head("pri.c", 8'hFF, 3'd0, 1'b1);
        pop();

        // Reset with two results buffered and an operation offered.
        offer(1'b0, 1'b0, 3'd3, 8'hFF);
        offer(1'b0, 1'b0, 3'd4, 8'hFF);
        check("pre.ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.sel_in = 3'd6;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("mrst.valid", 32'(bus.out_valid), 32'd0);
        check("mrst.ready", 32'(bus.in_ready),  32'd1);
        check("mrst.dec",   32'(bus.dec_out_b), 32'hFF);
        offer(1'b0, 1'b0, 3'd0, 8'hFF);
        head("post", 8'hFE, 3'd0, 1'b0);
        pop();
        check("post.empty", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/onehot_codec_pipe.md
ONEHOT_CODEC_PIPE -- requirements
Module: onehot_codec_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select/code width; N = 2**SEL_W lines; legal 1..6.
REQ-002 SHALL have parameter DEPTH, default 2, result buffer entries; legal 1..4.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en_b  input  1  active-low enable, sampled with the operation.
REQ-006 SHALL have port mode  input  1  0 = decode, 1 = encode.
REQ-007 SHALL have port in_valid  input  1  operation offered.
REQ-008 SHALL have port in_ready  output  1  operation accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port sel_in  input  SEL_W  decode operand.
REQ-010 SHALL have port req_b  input  N  encode operand, active-low request lines.
REQ-011 SHALL have port out_valid  output  1  result available at buffer head.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-013 SHALL have port dec_out_b  output  N  active-low one-hot decode result.
REQ-014 SHALL have port enc_out  output  SEL_W  encoded index of the winning request.
REQ-015 SHALL have port enc_hit  output  1  at least one request was active (encode mode, enabled).

Function
REQ-016 Decode, en_b=0: dec_out_b SHALL be all ones except bit sel_in = 0; enc_out=0, enc_hit=0.
REQ-017 Encode, en_b=0: enc_out SHALL be the winning active-low request index, enc_hit=1, dec_out_b all ones.
REQ-018 Encode, en_b=0, req_b all ones: enc_hit=0, enc_out=0, dec_out_b all ones.
REQ-019 en_b=1, either mode: dec_out_b all ones, enc_out all ones, enc_hit=0; a result entry is still produced.
REQ-020 Results SHALL be computed from inputs at the accept edge and written to a DEPTH-entry FIFO; output ports always reflect the head entry.
REQ-021 Latency: accept at edge k with buffer empty -> out_valid=1 after edge k, i.e. one cycle.
REQ-022 in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready to in_ready.
REQ-023 Full and out_ready=1: pop occurs, in_ready stays low that cycle; push next cycle.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
REQ-025 While out_valid=1 and out_ready=0, head outputs SHALL hold stable.
REQ-026 Results SHALL emerge in acceptance order; no loss, no duplication.
REQ-027 in_valid=0 or in_ready=0: no state change in the encode-priority logic.

Reset
REQ-028 With reset high at a clock edge: count=0, out_valid=0, in_ready=1 after that edge, dec_out_b all ones, enc_out=0, enc_hit=0, priority pointer=0.
REQ-029 Reset mid-operation SHALL discard all buffered results; operations offered during reset are not accepted.
REQ-030 Reset SHALL take precedence over push and pop in the same cycle.

Configuration
REQ-031 Macro ONEHOT_CODEC_RR_EN: when defined, encode priority rotates. Search starts at pointer p, ascending with wrap. After each accepted encode with enc_hit=1, p becomes (winner+1) mod N. Otherwise p is unchanged.
REQ-032 Without ONEHOT_CODEC_RR_EN: fixed priority, lowest active index wins, and no pointer register exists.

Verification (SEL_W=3, DEPTH=2)
REQ-033 After reset, decode sel_in=5, en_b=0, out_ready=1 -> next cycle out_valid=1, dec_out_b=1101_1111.
REQ-034 Encode req_b=1110_0111, en_b=0 -> enc_out=3, enc_hit=1 (fixed priority; RR with p=0 gives the same result).
REQ-035 out_ready=0, three back-to-back decodes sel 0,1,2 -> in_ready low after two accepts; release out_ready -> heads 1111_1110, 1111_1101, 1111_1011 in order.
REQ-036 en_b=1 decode sel_in=7 -> dec_out_b=1111_1111, enc_out=111, enc_hit=0; encode req_b all ones, en_b=0 -> enc_hit=0, enc_out=0.
REQ-037 RR_EN: three encodes req_b=1110_1110 (lines 0 and 4) -> enc_out 0, 4, 0.
REQ-038 Two results buffered, reset pulsed one cycle -> out_valid=0, in_ready=1, subsequent decode sel_in=0 yields 1111_1110.
